// File: rtl/count_seq_checker_pkg.sv
// count_seq_checker shared types and defaults.
// Imported by the interface, the checker and its counters.
package count_seq_checker_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED   = 2'd1,
      ERROR    = 2'd2
   } state_e;

   localparam int WIDTH_DEF    = 3;
   localparam int LOCK_CNT_DEF = 2;
   localparam int STAT_W_DEF   = 8;

endpackage

// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if: observed count in, lock/error status out.
// master drives the samples, slave is the checker.
interface count_seq_checker_if
   import count_seq_checker_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STAT_W = STAT_W_DEF
);

   logic [WIDTH-1:0]  cnt_in;
   logic              in_valid;
   logic              clear_err;
   logic              locked;
   logic              err;
   logic              wrap_pulse;
   logic [STAT_W-1:0] wrap_count;
   logic [STAT_W-1:0] err_count;

   modport master (
      output cnt_in,
      output in_valid,
      output clear_err,
      input  locked,
      input  err,
      input  wrap_pulse,
      input  wrap_count,
      input  err_count
   );

   modport slave (
      input  cnt_in,
      input  in_valid,
      input  clear_err,
      output locked,
      output err,
      output wrap_pulse,
      output wrap_count,
      output err_count
   );

endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter: saturating statistics counter.
// A clear and an increment on the same edge leave the count at 1.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear first, then count up unless already at max.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) cnt_d = '0;
      if (inc_i && (cnt_d != '1)) cnt_d = cnt_d + W'(1);
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: checks that a sampled count advances by +1.
// Locks on a clean run, counts wraps, flags and counts slips.
import count_seq_checker_pkg::*;

module count_seq_checker #(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF,
   parameter int STAT_W   = STAT_W_DEF
) (
   input logic               clk,
   input logic               reset,
   count_seq_checker_if.slave bus
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);

   state_e           state_q;
   logic [WIDTH-1:0] prev_q;
   logic             prev_valid_q;
   logic [RUN_W-1:0] run_q;
   logic             locked_q;
   logic             err_q;
   logic             wrap_pulse_q;

   logic [WIDTH-1:0] expect_w;
   logic             match_w;
   logic             wrap_w;
   logic             last_run_w;
   logic             err_evt_w;
   logic             wrap_evt_w;

   assign expect_w   = prev_q + WIDTH'(1);
   assign match_w    = prev_valid_q && (bus.cnt_in == expect_w);
   assign wrap_w     = (prev_q == '1) && (bus.cnt_in == '0);
   assign last_run_w = (run_q == RUN_W'(LOCK_CNT - 1));

   assign err_evt_w  = bus.in_valid && (state_q == LOCKED) && !match_w;
   assign wrap_evt_w = bus.in_valid && (state_q == LOCKED) &&
                       match_w && wrap_w;

   // Lock FSM, sample history and registered status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= UNLOCKED;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         run_q        <= '0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         wrap_pulse_q <= 1'b0;
      end else begin
         wrap_pulse_q <= 1'b0;
         if (bus.clear_err) err_q <= 1'b0;
         if (bus.in_valid) begin
            prev_q       <= bus.cnt_in;
            prev_valid_q <= 1'b1;
         end
         case (state_q)
            UNLOCKED, ERROR: begin
               if (bus.in_valid) begin
                  if (!match_w) begin
                     run_q <= '0;
                  end else if (last_run_w) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     run_q    <= '0;
                  end else begin
                     run_q <= run_q + RUN_W'(1);
                  end
               end
            end
            LOCKED: begin
               if (bus.in_valid) begin
                  if (!match_w) begin
                     state_q  <= ERROR;
                     locked_q <= 1'b0;
                     err_q    <= 1'b1;
                     run_q    <= '0;
                  end else if (wrap_w) begin
                     wrap_pulse_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q  <= UNLOCKED;
               locked_q <= 1'b0;
               run_q    <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(STAT_W)) u_wrap_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (wrap_evt_w),
      .clr_i (1'b0),
      .cnt_o (bus.wrap_count)
   );

   sat_counter #(.W(STAT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (err_evt_w),
      .clr_i (bus.clear_err),
      .cnt_o (bus.err_count)
   );

   assign bus.locked     = locked_q;
   assign bus.err        = err_q;
   assign bus.wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: scoreboard bench for count_seq_checker.
// Expected status is queued per driven sample, popped after the edge.
module tb_count_seq_checker;
   import count_seq_checker_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;

   count_seq_checker_if bus ();

   count_seq_checker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       l;
      logic       e;
      logic       w;
      logic [7:0] wc;
      logic [7:0] ec;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   int   m_st, m_prev, m_pv, m_run, m_wc, m_ec;
   logic m_l, m_e, m_w;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Behavioural reference of the checker, one call per edge.
   task automatic model(input logic v, input int c,
                        input logic clr, input logic rst);
      bit match;
      bit wrapv;
      if (rst) begin
         m_st = 0; m_prev = 0; m_pv = 0; m_run = 0;
         m_l = 0; m_e = 0; m_w = 0; m_wc = 0; m_ec = 0;
         return;
      end
      m_w = 0;
      if (clr) begin
         m_e = 0;
         m_ec = 0;
      end
      if (v) begin
         match = (m_pv == 1) && (c == ((m_prev + 1) % 8));
         wrapv = (m_prev == 7) && (c == 0);
         if (m_st == 1) begin
            if (match) begin
               if (wrapv) begin
                  m_w = 1;
                  if (m_wc < 255) m_wc++;
               end
            end else begin
               m_st = 2; m_l = 0; m_e = 1; m_run = 0;
               if (m_ec < 255) m_ec++;
            end
         end else begin
            if (match) begin
               m_run++;
               if (m_run == LOCK_CNT_DEF) begin
                  m_st = 1; m_l = 1; m_run = 0;
               end
            end else begin
               m_run = 0;
            end
         end
         m_prev = c;
         m_pv = 1;
      end
   endtask

   task automatic step(input logic v, input int c,
                       input logic clr, input logic rst);
      exp_t e;
      exp_t got;
      reset         = rst;
      bus.in_valid  = v;
      bus.cnt_in    = 3'(c);
      bus.clear_err = clr;
      model(v, c, clr, rst);
      e.l  = m_l;
      e.e  = m_e;
      e.w  = m_w;
      e.wc = 8'(m_wc);
      e.ec = 8'(m_ec);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("locked", {31'd0, bus.locked}, {31'd0, got.l});
      chk("err", {31'd0, bus.err}, {31'd0, got.e});
      chk("wrap_pulse", {31'd0, bus.wrap_pulse}, {31'd0, got.w});
      chk("wrap_count", {24'd0, bus.wrap_count}, {24'd0, got.wc});
      chk("err_count", {24'd0, bus.err_count}, {24'd0, got.ec});
   endtask

   task automatic drv(input int c);
      step(1'b1, c, 1'b0, 1'b0);
   endtask

   task automatic gap();
      step(1'b0, int'($urandom_range(0, 7)), 1'b0, 1'b0);
   endtask

   int p;

   initial begin
      bus.cnt_in    = '0;
      bus.in_valid  = 1'b0;
      bus.clear_err = 1'b0;

      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      chk("rst_locked", {31'd0, bus.locked}, 32'd0);
      chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);

      // Lock onto 0,1,2.
      for (int v = 0; v < 3; v++) drv(v);
      chk("lock_012", {31'd0, bus.locked}, 32'd1);
      chk("lock_err", {31'd0, bus.err}, 32'd0);
      chk("lock_wc", {24'd0, bus.wrap_count}, 32'd0);

      // First wrap, then 8 full loops.
      for (int v = 3; v < 8; v++) drv(v);
      drv(0);
      chk("wrap_hi", {31'd0, bus.wrap_pulse}, 32'd1);
      drv(1);
      chk("wrap_lo", {31'd0, bus.wrap_pulse}, 32'd0);
      chk("wc_one", {24'd0, bus.wrap_count}, 32'd1);
      for (int k = 0; k < 8; k++)
         for (int j = 2; j < 10; j++) drv(j % 8);
      chk("wc_nine", {24'd0, bus.wrap_count}, 32'd9);

      // Skip 3 -> 5, then relock on 6,7.
      drv(2);
      drv(3);
      drv(5);
      chk("skip_locked", {31'd0, bus.locked}, 32'd0);
      chk("skip_err", {31'd0, bus.err}, 32'd1);
      chk("skip_ec", {24'd0, bus.err_count}, 32'd1);
      drv(6);
      drv(7);
      chk("relock", {31'd0, bus.locked}, 32'd1);
      chk("relock_err", {31'd0, bus.err}, 32'd1);

      // Stuck value, clear, clear colliding with an error.
      for (int v = 0; v < 5; v++) drv(v);
      drv(4);
      chk("stuck_ec", {24'd0, bus.err_count}, 32'd2);
      drv(5);
      drv(6);
      step(1'b1, 7, 1'b1, 1'b0);
      chk("clr_err", {31'd0, bus.err}, 32'd0);
      chk("clr_ec", {24'd0, bus.err_count}, 32'd0);
      chk("clr_locked", {31'd0, bus.locked}, 32'd1);
      step(1'b1, 3, 1'b1, 1'b0);
      chk("clr_hit_err", {31'd0, bus.err}, 32'd1);
      chk("clr_hit_ec", {24'd0, bus.err_count}, 32'd1);

      // Gaps in in_valid around a wrap.
      drv(4);
      drv(5);
      drv(6);
      drv(7);
      drv(0);
      chk("gap_wrap", {31'd0, bus.wrap_pulse}, 32'd1);
      gap();
      chk("gap_pulse", {31'd0, bus.wrap_pulse}, 32'd0);
      gap();
      drv(1);
      chk("gap_locked", {31'd0, bus.locked}, 32'd1);
      chk("gap_wc", {24'd0, bus.wrap_count}, 32'd11);

      // Build err_count=3 while locked, then reset.
      drv(3);
      drv(4);
      drv(5);
      drv(7);
      drv(0);
      drv(1);
      chk("pre_rst_ec", {24'd0, bus.err_count}, 32'd3);
      step(1'b1, 2, 1'b0, 1'b1);
      chk("mid_rst_locked", {31'd0, bus.locked}, 32'd0);
      chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
      chk("mid_rst_wc", {24'd0, bus.wrap_count}, 32'd0);
      chk("mid_rst_ec", {24'd0, bus.err_count}, 32'd0);

      // Unlocked mismatch raises nothing; relock needs fresh run.
      drv(5);
      drv(7);
      chk("unl_err", {31'd0, bus.err}, 32'd0);
      drv(0);
      chk("unl_locked", {31'd0, bus.locked}, 32'd0);
      drv(1);
      chk("unl_relock", {31'd0, bus.locked}, 32'd1);
      chk("unl_wc", {24'd0, bus.wrap_count}, 32'd0);

      // Saturate err_count with 258 errors.
      p = 1;
      for (int k = 0; k < 258; k++) begin
         drv((p + 2) % 8);
         drv((p + 3) % 8);
         drv((p + 4) % 8);
         p = (p + 4) % 8;
      end
      chk("sat_ec", {24'd0, bus.err_count}, 32'd255);
      chk("sat_err", {31'd0, bus.err}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
